// File: rtl/point_test_pkg.sv
// Shared types and sideband message codes for the D2C point-test block.
// The arbiter state encoding is visible on its debug port, so it lives here too.
package point_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } pt_state_t;

    typedef struct packed {
        logic [3:0]  msg;
        logic [15:0] data;
        logic        info;
        logic        data_valid;
    } sb_msg_t;

    localparam logic [3:0] MSG_TEST_REQ        = 4'b0001;
    localparam logic [3:0] MSG_TEST_RESP       = 4'b0010;
    localparam logic [3:0] MSG_LFSR_CLEAR_REQ  = 4'b0011;
    localparam logic [3:0] MSG_LFSR_CLEAR_RESP = 4'b0100;
    localparam logic [3:0] MSG_RESULT_REQ      = 4'b0101;
    localparam logic [3:0] MSG_RESULT_RESP     = 4'b0110;
    localparam logic [3:0] MSG_END_REQ         = 4'b0111;
    localparam logic [3:0] MSG_END_RESP        = 4'b1000;

    // Round-robin pick: a lone requester wins; on a tie the side not granted last wins.
    function automatic logic pick_rx(input logic valid_tx, input logic valid_rx,
                                     input logic last_rx);
        return valid_rx && (!valid_tx || !last_rx);
    endfunction

endpackage

// File: rtl/point_test_sb_arbiter.sv
// Shares the single sideband transmit path between the TX and RX point-test FSMs,
// returning a per-owner completion pulse and aborting messages the encoder never takes.
//
// Handshake: a requester raises i_valid_* with stable fields and holds it until its
// o_done_* pulse; the grant latches the fields, o_sb_valid stays high until the encoder
// has raised and then dropped i_sb_busy, and the requester drops valid on the DONE edge.
module point_test_sb_arbiter
    import point_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_valid_tx,
    input  logic [3:0]  i_msg_tx,
    input  logic [15:0] i_data_tx,
    input  logic        i_info_tx,
    input  logic        i_data_valid_tx,
    input  logic        i_valid_rx,
    input  logic [3:0]  i_msg_rx,
    input  logic [15:0] i_data_rx,
    input  logic        i_info_rx,
    input  logic        i_data_valid_rx,
    input  logic        i_sb_busy,
    output logic        o_sb_valid,
    output logic [3:0]  o_sb_msg,
    output logic [15:0] o_sb_data,
    output logic        o_sb_info,
    output logic        o_sb_data_valid,
    output logic        o_done_tx,
    output logic        o_done_rx,
    output logic        o_owner_rx,
    output logic        o_timeout,
    output logic [1:0]  o_dbg_state
);

    pt_state_t        state_q, state_d;
    sb_msg_t          fields_q, fields_d;
    logic             owner_rx_q, owner_rx_d;
    logic             last_rx_q, last_rx_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             en_low_q, en_low_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fields_q   <= '0;
            owner_rx_q <= 1'b0;
            last_rx_q  <= 1'b1;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            en_low_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fields_q   <= fields_d;
            owner_rx_q <= owner_rx_d;
            last_rx_q  <= last_rx_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
            en_low_q   <= en_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fields_d   = fields_q;
        owner_rx_d = owner_rx_q;
        last_rx_d  = last_rx_q;
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = timeout_q;
        en_low_d   = en_low_q || !i_en;

        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid_tx || i_valid_rx) begin
                        state_d    = ST_ISSUE;
                        owner_rx_d = pick_rx(i_valid_tx, i_valid_rx, last_rx_q);
                        fields_d   = owner_rx_d
                            ? '{msg: i_msg_rx, data: i_data_rx, info: i_info_rx,
                                data_valid: i_data_valid_rx}
                            : '{msg: i_msg_tx, data: i_data_tx, info: i_info_tx,
                                data_valid: i_data_valid_tx};
                        wd_cnt_d   = '0;
                        en_low_d   = 1'b0;
                        // A grant after the enable was dropped starts a fresh test run.
                        if (en_low_q) timeout_d = 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (i_sb_busy) begin
                        state_d = ST_BUSY;
                    end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (!i_sb_busy) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d   = ST_IDLE;
                    last_rx_d = owner_rx_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Valid and done are gated by i_en so an abort takes effect in the same cycle.
    assign o_sb_valid      = i_en && (state_q == ST_ISSUE || state_q == ST_BUSY);
    assign o_done_tx       = i_en && (state_q == ST_DONE) && !owner_rx_q;
    assign o_done_rx       = i_en && (state_q == ST_DONE) && owner_rx_q;
    assign o_sb_msg        = fields_q.msg;
    assign o_sb_data       = fields_q.data;
    assign o_sb_info       = fields_q.info;
    assign o_sb_data_valid = fields_q.data_valid;
    assign o_owner_rx      = owner_rx_q;
    assign o_timeout       = timeout_q;
    assign o_dbg_state     = state_q;

endmodule
